// File: rtl/avg_filter_3x3_8bit_if.sv
// Window-side and output-side signals of the 3x3 mean filter.
// master = window source / output consumer, slave = the filter itself.
interface avg_filter_3x3_8bit_if;
    logic       matrix_img_vsync;
    logic       matrix_img_href;
    logic       matrix_top_edge_flag;
    logic       matrix_bottom_edge_flag;
    logic       matrix_left_edge_flag;
    logic       matrix_right_edge_flag;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_gray;

    modport master (
        output matrix_img_vsync, matrix_img_href,
        output matrix_top_edge_flag, matrix_bottom_edge_flag,
        output matrix_left_edge_flag, matrix_right_edge_flag,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_img_vsync, post_img_href, post_img_gray
    );

    modport slave (
        input  matrix_img_vsync, matrix_img_href,
        input  matrix_top_edge_flag, matrix_bottom_edge_flag,
        input  matrix_left_edge_flag, matrix_right_edge_flag,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_img_vsync, post_img_href, post_img_gray
    );
endinterface

// File: rtl/avg_filter_3x3_8bit.sv
// 3x3 mean filter, fixed 3-cycle latency. AVG_EDGE_REPLICATE_EN selects edge
// replication; without it, border windows pass the centre pixel through.
module avg_filter_3x3_8bit #(
    parameter int unsigned DIV_MULT  = 7282,
    parameter int unsigned DIV_SHIFT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    avg_filter_3x3_8bit_if.slave        bus
);
    logic [7:0]  p [3][3];
    logic [7:0]  q [3][3];
    logic [9:0]  r1, r2, r3;
    logic [11:0] sum;
    logic [31:0] prod, quot;
    logic [7:0]  avg;
    logic [7:0]  gray;
    logic [2:0]  vsync_sr, href_sr;

    always_comb begin
        p[0][0] = bus.matrix_p11; p[0][1] = bus.matrix_p12; p[0][2] = bus.matrix_p13;
        p[1][0] = bus.matrix_p21; p[1][1] = bus.matrix_p22; p[1][2] = bus.matrix_p23;
        p[2][0] = bus.matrix_p31; p[2][1] = bus.matrix_p32; p[2][2] = bus.matrix_p33;
    end

`ifdef AVG_EDGE_REPLICATE_EN
    // Columns first, then rows copy the already-padded middle row, so corners get p22.
    always_comb begin
        q = p;
        for (int unsigned r = 0; r < 3; r++) begin
            if (bus.matrix_left_edge_flag)  q[r][0] = p[r][1];
            if (bus.matrix_right_edge_flag) q[r][2] = p[r][1];
        end
        for (int unsigned c = 0; c < 3; c++) begin
            if (bus.matrix_top_edge_flag)    q[0][c] = q[1][c];
            if (bus.matrix_bottom_edge_flag) q[2][c] = q[1][c];
        end
    end
`else
    logic       any_edge;
    logic [7:0] center_s1, center_s2;
    logic       edge_s1, edge_s2;

    always_comb begin
        q = p;
        any_edge = bus.matrix_top_edge_flag | bus.matrix_bottom_edge_flag |
                   bus.matrix_left_edge_flag | bus.matrix_right_edge_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            center_s1 <= '0;
            center_s2 <= '0;
            edge_s1   <= 1'b0;
            edge_s2   <= 1'b0;
        end else begin
            center_s1 <= bus.matrix_p22;
            center_s2 <= center_s1;
            edge_s1   <= any_edge;
            edge_s2   <= edge_s1;
        end
    end
`endif

    always_comb begin
        prod = 32'(sum) * DIV_MULT + (32'd1 << (DIV_SHIFT - 1));
        quot = prod >> DIV_SHIFT;
        avg  = (quot > 32'd255) ? 8'hFF : quot[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            sum      <= '0;
            gray     <= '0;
            vsync_sr <= '0;
            href_sr  <= '0;
        end else begin
            r1       <= 10'(q[0][0]) + 10'(q[0][1]) + 10'(q[0][2]);
            r2       <= 10'(q[1][0]) + 10'(q[1][1]) + 10'(q[1][2]);
            r3       <= 10'(q[2][0]) + 10'(q[2][1]) + 10'(q[2][2]);
            sum      <= 12'(r1) + 12'(r2) + 12'(r3);
`ifdef AVG_EDGE_REPLICATE_EN
            gray     <= avg;
`else
            gray     <= edge_s2 ? center_s2 : avg;
`endif
            vsync_sr <= {vsync_sr[1:0], bus.matrix_img_vsync};
            href_sr  <= {href_sr[1:0], bus.matrix_img_href};
        end
    end

    assign bus.post_img_vsync = vsync_sr[2];
    assign bus.post_img_href  = href_sr[2];
    assign bus.post_img_gray  = gray;
endmodule

// File: tb/tb_avg_filter_3x3_8bit.sv
// Self-checking bench for avg_filter_3x3_8bit: reference model computes the
// padded 3x3 mean with exact round-half-up division and a 3-deep expectation queue.
module tb_avg_filter_3x3_8bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avg_filter_3x3_8bit_if bus ();

    avg_filter_3x3_8bit #(.DIV_MULT(7282), .DIV_SHIFT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic [7:0] gray;
    } exp_t;

    exp_t pipe[$];
    exp_t cur = '0;

`ifdef AVG_EDGE_REPLICATE_EN
    localparam logic [7:0] TL_EXP = 8'd53;
    localparam logic [7:0] BR_EXP = 8'd27;
`else
    localparam logic [7:0] TL_EXP = 8'd90;
    localparam logic [7:0] BR_EXP = 8'd10;
`endif

    // w[3*r+c] is pixel p(r+1)(c+1); f = {top, bottom, left, right}
    function automatic logic [7:0] ref_mean(input logic [8:0][7:0] w, input logic [3:0] f);
        int s = 0;
        int rr, cc;
`ifndef AVG_EDGE_REPLICATE_EN
        if (f != 4'b0) return w[4];
`endif
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rr = r;
                cc = c;
                if (c == 0 && f[1]) cc = 1;
                if (c == 2 && f[0]) cc = 1;
                if (r == 0 && f[3]) rr = 1;
                if (r == 2 && f[2]) rr = 1;
                s += int'(w[rr*3+cc]);
            end
        end
        s = (2 * s + 9) / 18;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [8:0][7:0] fill(input logic [7:0] v);
        logic [8:0][7:0] w;
        for (int i = 0; i < 9; i++) w[i] = v;
        return w;
    endfunction

    function automatic logic [8:0][7:0] cur_window();
        logic [8:0][7:0] w;
        w[0] = bus.matrix_p11; w[1] = bus.matrix_p12; w[2] = bus.matrix_p13;
        w[3] = bus.matrix_p21; w[4] = bus.matrix_p22; w[5] = bus.matrix_p23;
        w[6] = bus.matrix_p31; w[7] = bus.matrix_p32; w[8] = bus.matrix_p33;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe = {};
            pipe.push_back('0);
            pipe.push_back('0);
            cur = '0;
        end else begin
            exp_t e;
            e.vsync = bus.matrix_img_vsync;
            e.href  = bus.matrix_img_href;
            e.gray  = ref_mean(cur_window(),
                               {bus.matrix_top_edge_flag, bus.matrix_bottom_edge_flag,
                                bus.matrix_left_edge_flag, bus.matrix_right_edge_flag});
            pipe.push_back(e);
            cur = pipe.pop_front();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_href",  bus.post_img_href,  0);
            check("rst_vsync", bus.post_img_vsync, 0);
            check("rst_gray",  bus.post_img_gray,  0);
        end else begin
            check("vsync", bus.post_img_vsync, cur.vsync);
            check("href",  bus.post_img_href,  cur.href);
            if (cur.href) check("gray", bus.post_img_gray, cur.gray);
        end
    end

    task automatic drive(input logic [8:0][7:0] w, input logic [3:0] f,
                         input logic vs, input logic hs);
        @(posedge clk);
        #1;
        bus.matrix_p11 = w[0]; bus.matrix_p12 = w[1]; bus.matrix_p13 = w[2];
        bus.matrix_p21 = w[3]; bus.matrix_p22 = w[4]; bus.matrix_p23 = w[5];
        bus.matrix_p31 = w[6]; bus.matrix_p32 = w[7]; bus.matrix_p33 = w[8];
        bus.matrix_top_edge_flag    = f[3];
        bus.matrix_bottom_edge_flag = f[2];
        bus.matrix_left_edge_flag   = f[1];
        bus.matrix_right_edge_flag  = f[0];
        bus.matrix_img_vsync = vs;
        bus.matrix_img_href  = hs;
    endtask

    task automatic directed(input string name, input logic [8:0][7:0] w,
                            input logic [3:0] f, input logic [7:0] lit);
        check({name, "_model"}, ref_mean(w, f), lit);
        drive(w, f, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_dut"}, bus.post_img_gray, lit);
    endtask

    function automatic logic [8:0][7:0] rand_window();
        logic [8:0][7:0] w;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
        return w;
    endfunction

    function automatic logic [3:0] rand_flags();
        return ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
    endfunction

    initial begin
        logic [8:0][7:0] w;
        drive(fill(8'd0), 4'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Flat frame
        for (int i = 0; i < 12; i++) drive(fill(8'd100), 4'b0, 1'b1, 1'b1);
        drive(fill(8'd100), 4'b0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) w[i] = 8'(i + 1);
        directed("ramp", w, 4'b0, 8'd5);
        directed("white", fill(8'd255), 4'b0, 8'd255);
        directed("flat100", fill(8'd100), 4'b0, 8'd100);
        w = fill(8'd0); w[4] = 8'd13;
        directed("sum13", w, 4'b0, 8'd1);
        w[4] = 8'd4;
        directed("sum4", w, 4'b0, 8'd0);
        w[4] = 8'd5;
        directed("sum5", w, 4'b0, 8'd1);

        w = fill(8'd99); w[4] = 8'd90; w[5] = 8'd0; w[7] = 8'd30; w[8] = 8'd60;
        directed("top_left", w, 4'b1010, TL_EXP);
        w = fill(8'd200); w[0] = 8'd40; w[1] = 8'd40; w[3] = 8'd40; w[4] = 8'd10;
        directed("bottom_right", w, 4'b0101, BR_EXP);

        // Alternating 0/255 burst with no bubble
        for (int i = 0; i < 8; i++) drive(fill((i % 2 == 0) ? 8'd0 : 8'd255), 4'b0, 1'b1, 1'b1);
        drive(fill(8'd0), 4'b0, 1'b1, 1'b0);
        drive(fill(8'd0), 4'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            drive(rand_window(), rand_flags(), ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 3) != 0));

        // Mid-line reset
        for (int i = 0; i < 6; i++) drive(rand_window(), rand_flags(), 1'b1, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_href",  bus.post_img_href,  0);
        check("async_rst_vsync", bus.post_img_vsync, 0);
        check("async_rst_gray",  bus.post_img_gray,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(rand_window(), rand_flags(), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(fill(8'd0), 4'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
